uart_rx_cfg: RTL and testbench

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver.
- Configurable data width, oversampling ratio, parity mode and stop-bit count.
- Mid-bit sampling with false-start rejection.
- Parity, framing and overrun error reporting.
- Valid/ready output handshake.
- Sits between the serial pin (after pad) and a byte/word consumer such as a FIFO or register bank.

---
 rtl/uart_rx_cfg.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, 1/2 stop bits, valid/ready output.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around the bit midpoint.
//   state    | meaning
//   S_IDLE   | line idle, waiting for rx_s low
//   S_START  | confirming start bit at its midpoint
//   S_DATA   | shifting in DATA_BITS data bits, LSB first
//   S_PARITY | sampling the parity bit
//   S_STOP   | sampling one or two stop bits, then delivering
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 stop_bits_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(CLK_PER_BIT / 2);
`else
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(CLK_PER_BIT / 2 - 1);
`endif
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   sample_bit;
  logic                   sample_tick;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          bit_idx_q;
  logic                   stop_idx_q;
  logic [1:0]             par_mode_q;
  logic                   stop_two_q;
  logic                   par_en;
  logic                   par_odd;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_acc_q;
  logic                   par_err_q;
  logic                   frame_err_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   overrun_q;

  logic latch_mode, bit_clr, shift_en, par_chk, stop_chk, deliver;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rx_s from the two cycles before the decision cycle
  logic [1:0] hist_q;
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  end
  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  assign sample_tick = (cnt_q == SAMPLE_CNT);
  assign par_en      = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  assign par_odd     = (par_mode_q == 2'b10);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    latch_mode = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_chk   = 1'b0;
    deliver    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          latch_mode = 1'b1;
          state_nxt  = S_START;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (sample_bit) begin
            state_nxt = S_IDLE;
          end else begin
            bit_clr   = 1'b1;
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          shift_en = 1'b1;
          if (bit_idx_q == LAST_BIT) state_nxt = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample_tick) begin
          par_chk   = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          stop_chk = 1'b1;
          if (!(stop_two_q && !stop_idx_q)) begin
            deliver   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      par_mode_q  <= 2'b00;
      stop_two_q  <= 1'b0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE)    cnt_q <= '0;
      else if (cnt_q == CNT_MAX) cnt_q <= '0;
      else                       cnt_q <= cnt_q + CW'(1);

      if (latch_mode) begin
        par_mode_q  <= parity_mode_i;
        stop_two_q  <= stop_bits_i;
        par_acc_q   <= 1'b0;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (bit_clr) begin
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
      end
      if (shift_en) begin
        shift_q   <= {sample_bit, shift_q[DATA_BITS-1:1]};
        par_acc_q <= par_acc_q ^ sample_bit;
        bit_idx_q <= bit_idx_q + IW'(1);
      end
      // odd mode flags an error when the running XOR comes out even
      if (par_chk) par_err_q <= par_acc_q ^ sample_bit ^ par_odd;
      if (stop_chk) begin
        stop_idx_q <= 1'b1;
        if (!sample_bit) frame_err_q <= 1'b1;
      end

      overrun_q <= 1'b0;
      if (deliver) begin
        if (!valid_q || ready_i) begin
          data_q  <= shift_q;
          perr_q  <= par_err_q;
          ferr_q  <= frame_err_q | ~sample_bit;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at default parameters: framing, parity, stop bits,
// false start, overrun/handshake and mid-frame reset.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic [1:0] parity_mode_i = 2'b00;
  logic       stop_bits_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

  uart_rx_cfg dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .parity_mode_i(parity_mode_i),
    .stop_bits_i(stop_bits_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t;
  } word_t;

  word_t wq[$];
  int    ovr_cnt = 0;
  int    vcyc = 0;
  logic  v_prev = 1'b0;
  logic  r_prev = 1'b0;

  // a new word is visible when valid rises or reloads right after a handshake
  always @(negedge clk) begin
    if (rst) begin
      v_prev = 1'b0;
      r_prev = 1'b0;
    end else begin
      if (valid_o && (!v_prev || r_prev))
        wq.push_back('{d: data_o, pe: parity_err_o, fe: frame_err_o, t: cyc});
      if (overrun_o) ovr_cnt++;
      if (valid_o) vcyc++;
      v_prev = valid_o;
      r_prev = ready_i;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    tick(CPB);
  endtask

  int t_start;
  int last_t;

  task automatic send_frame(input logic [7:0] d, input bit pen, input logic pb,
                            input bit two, input logic s2);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pb);
    drive_bit(1'b1);
    if (two) drive_bit(s2);
    rx_i = 1'b1;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    int    n;
    word_t w;
    n = 0;
    while (wq.size() == 0 && n < 400) begin
      tick(1);
      n++;
    end
    check_val({tag, "_present"}, 32'(wq.size() > 0), 32'd1);
    last_t = -1;
    if (wq.size() > 0) begin
      w = wq.pop_front();
      last_t = w.t;
      check_val({tag, "_data"}, 32'(w.d), 32'(d));
      check_val({tag, "_perr"}, 32'(w.pe), 32'(pe));
      check_val({tag, "_ferr"}, 32'(w.fe), 32'(fe));
    end
  endtask

  initial begin
    int v0, o0;
    tick(4);
    check_val("rst_valid", 32'(valid_o), 0);
    check_val("rst_data", 32'(data_o), 0);
    check_val("rst_busy", 32'(busy_o), 0);
    check_val("rst_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 0);
    rst = 1'b0;
    tick(4);

    // 8N1 0xA5 with latency and one-cycle valid
    v0 = vcyc;
    send_frame(8'hA5, 0, 1'b0, 0, 1'b1);
    tick(8);
    expect_word("t1", 8'hA5, 1'b0, 1'b0);
    check_val("t1_lat", 32'(last_t), 32'(t_start + 155));
    check_val("t1_vwidth", 32'(vcyc - v0), 1);
    check_val("t1_busy", 32'(busy_o), 0);
    tick(32);

    // parity modes
    parity_mode_i = 2'b01;
    send_frame(8'h03, 1, 1'b1, 0, 1'b1);
    expect_word("t2_even_bad", 8'h03, 1'b1, 1'b0);
    check_val("t2_lat", 32'(last_t), 32'(t_start + 171));
    tick(32);
    send_frame(8'h03, 1, 1'b0, 0, 1'b1);
    expect_word("t2_even_ok", 8'h03, 1'b0, 1'b0);
    tick(32);
    parity_mode_i = 2'b10;
    send_frame(8'h03, 1, 1'b1, 0, 1'b1);
    expect_word("t2_odd_ok", 8'h03, 1'b0, 1'b0);
    tick(32);
    send_frame(8'h03, 1, 1'b0, 0, 1'b1);
    expect_word("t2_odd_bad", 8'h03, 1'b1, 1'b0);
    tick(32);
    parity_mode_i = 2'b00;

    // two stop bits, second one low
    stop_bits_i = 1'b1;
    send_frame(8'h5A, 0, 1'b0, 1, 1'b0);
    tick(32);
    expect_word("t3_two", 8'h5A, 1'b0, 1'b1);
    check_val("t3_lat", 32'(last_t), 32'(t_start + 171));
    check_val("t3_noextra", 32'(wq.size()), 0);
    check_val("t3_busy", 32'(busy_o), 0);
    stop_bits_i = 1'b0;
    send_frame(8'h5A, 0, 1'b0, 1, 1'b0);
    expect_word("t3_one", 8'h5A, 1'b0, 1'b0);
    expect_word("t3_restart", 8'hFF, 1'b0, 1'b0);
    tick(32);

    // false start
    rx_i = 1'b0;
    tick(5);
    rx_i = 1'b1;
    tick(2);
    check_val("t4_busy_hi", 32'(busy_o), 1);
    tick(20);
    check_val("t4_busy_lo", 32'(busy_o), 0);
    check_val("t4_noword", 32'(wq.size()), 0);
    send_frame(8'h3C, 0, 1'b0, 0, 1'b1);
    expect_word("t4_next", 8'h3C, 1'b0, 1'b0);
    tick(32);

    // overrun with output held
    ready_i = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 0, 1'b0, 0, 1'b1);
    send_frame(8'h22, 0, 1'b0, 0, 1'b1);
    tick(40);
    check_val("t5_nwords", 32'(wq.size()), 1);
    expect_word("t5_held", 8'h11, 1'b0, 1'b0);
    check_val("t5_ovr", 32'(ovr_cnt - o0), 1);
    check_val("t5_valid", 32'(valid_o), 1);
    check_val("t5_data", 32'(data_o), 32'h11);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    check_val("t5_hs_valid", 32'(valid_o), 0);
    check_val("t5_noreload", 32'(wq.size()), 0);
    tick(8);

    // reset mid-frame with a word held
    send_frame(8'h3C, 0, 1'b0, 0, 1'b1);
    tick(8);
    expect_word("t6_pre", 8'h3C, 1'b0, 1'b0);
    check_val("t6_pre_valid", 32'(valid_o), 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx_i = 1'b0;
    tick(8);
    check_val("t6_busy_mid", 32'(busy_o), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_i = 1'b1;
    check_val("t6_valid", 32'(valid_o), 0);
    check_val("t6_data", 32'(data_o), 0);
    check_val("t6_busy", 32'(busy_o), 0);
    check_val("t6_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 0);
    tick(3);
    check_val("t6_busy_after", 32'(busy_o), 0);
    tick(32);
    ready_i = 1'b1;
    send_frame(8'h88, 0, 1'b0, 0, 1'b1);
    tick(8);
    expect_word("t6_post", 8'h88, 1'b0, 1'b0);
    check_val("t6_lat", 32'(last_t), 32'(t_start + 155));
    check_val("t6_noextra", 32'(wq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
